// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: 16x-oversampling 8-bit UART receiver with a one-byte
// show-ahead holding register read through re/r_data/empty.
// Optional build macro UART_RX_PARITY_EN adds an even-parity bit (8E1);
// without it frames are 8N1.
module uart_rx_buffer #(
  parameter int unsigned DIVISOR = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       re,
  output logic [7:0] r_data,
  output logic       empty,
  output logic       frame_err,
  output logic       overrun
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef UART_RX_PARITY_EN
    , PARITY
`endif
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(DIVISOR - 1);

  logic        rx_meta;
  logic        rx_s;
  logic [15:0] div_cnt;
  logic        tick;
  state_t      state;
  logic [3:0]  tick_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        frame_done;
  logic        frame_ok;
`ifdef UART_RX_PARITY_EN
  logic        par_ok;
`endif

  // Two-flop synchroniser for the asynchronous serial input (idle high)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Free-running oversample tick divider, 0..DIVISOR-1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  // Stop-bit sample point and frame validity
  assign frame_done = (state == STOP) && tick && (tick_cnt == 4'd15);
`ifdef UART_RX_PARITY_EN
  assign frame_ok   = rx_s & par_ok;
`else
  assign frame_ok   = rx_s;
`endif

  // Receive FSM: start-bit qualification, LSB-first data shift, stop sample
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
`ifdef UART_RX_PARITY_EN
      par_ok   <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            tick_cnt <= '0;
            state    <= START;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt == 4'd7) begin
              tick_cnt <= '0;
              bit_idx  <= '0;
              state    <= rx_s ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tick_cnt == 4'd15) begin
              tick_cnt <= '0;
              shreg    <= {rx_s, shreg[7:1]};
              if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (tick_cnt == 4'd15) begin
              tick_cnt <= '0;
              par_ok   <= ~(^{shreg, rx_s});
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (tick_cnt == 4'd15) begin
              tick_cnt <= '0;
              state    <= IDLE;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Holding register and sticky flags; a load or flag-set beats a same-cycle read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data    <= '0;
      empty     <= 1'b1;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (frame_done && frame_ok && (empty || re)) begin
        r_data <= shreg;
        empty  <= 1'b0;
      end else if (re && !empty) begin
        empty <= 1'b1;
      end

      if (frame_done && !frame_ok) begin
        frame_err <= 1'b1;
      end else if (re) begin
        frame_err <= 1'b0;
      end

      // A read in the load cycle consumed the old byte, so no overrun then
      if (frame_done && frame_ok && !empty && !re) begin
        overrun <= 1'b1;
      end else if (re) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb_uart_rx_buffer: scoreboard bench for uart_rx_buffer at DIVISOR=1
// (one bit = 16 clocks). Build with UART_RX_PARITY_EN to exercise 8E1.
module tb_uart_rx_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       re;
  logic [7:0] r_data;
  logic       empty;
  logic       frame_err;
  logic       overrun;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  // Reference model of the holding register and flags
  bit       m_empty = 1'b1;
  bit [7:0] m_rdata = 8'h00;
  bit       m_ferr  = 1'b0;
  bit       m_ovr   = 1'b0;
  logic [7:0] sb_q[$];

  uart_rx_buffer #(.DIVISOR(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .re        (re),
    .r_data    (r_data),
    .empty     (empty),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string name);
    check({name, "_empty"},     32'(empty),     32'(m_empty));
    check({name, "_r_data"},    32'(r_data),    32'(m_rdata));
    check({name, "_frame_err"}, 32'(frame_err), 32'(m_ferr));
    check({name, "_overrun"},   32'(overrun),   32'(m_ovr));
  endtask

  task automatic model_read();
    m_empty = 1'b1;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic do_read(input string name);
    re = 1'b1;
    step();
    re = 1'b0;
    model_read();
    check_state(name);
  endtask

  // Sends one frame; with re_at_load the read strobe lands on the load clock
  task automatic send_frame(input logic [7:0] d, input bit bad_stop, input bit bad_par,
                            input bit re_at_load, input string name);
    bit good;
    bit load;
    if (re_at_load) model_read();
    good = !bad_stop && !bad_par;
    load = good && m_empty;
    if (good) begin
      if (m_empty) begin
        sb_q.push_back(d);
        m_empty = 1'b0;
        m_rdata = d;
      end else begin
        m_ovr = 1'b1;
      end
    end else begin
      m_ferr = 1'b1;
    end

    rx = 1'b0;
    repeat (16) step();
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (16) step();
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ bad_par;
    repeat (16) step();
`endif
    rx = !bad_stop;
    repeat (10) step();
    if (re_at_load) re = 1'b1;
    step();
    re = 1'b0;
    if (load) check({name, "_load_latency"}, 32'(empty), 32'd0);
    repeat (5) step();
    rx = 1'b1;
    check_state(name);
  endtask

  // Monitor: every newly presented byte must match the scoreboard head
  initial begin
    logic       prev_empty;
    logic [7:0] prev_rd;
    logic [7:0] exp;
    prev_empty = 1'b1;
    prev_rd    = 8'h00;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && empty === 1'b0 && (prev_empty === 1'b1 || r_data !== prev_rd)) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_load: got %0h expected no byte", r_data);
        end else begin
          exp = sb_q.pop_front();
          check("load_data", 32'(r_data), 32'(exp));
        end
      end
      prev_empty = empty;
      prev_rd    = r_data;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bit [7:0] d;
    bit       bs;
    bit       bp;
    reset = 1'b0;
    rx    = 1'b1;
    re    = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    repeat (100) step();
    check_state("reset");

    // Basic receive and read
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, "basic");
    do_read("basic_read");
    repeat (10) step();

    // Overrun: two back-to-back frames without reading
    send_frame(8'hAA, 1'b0, 1'b0, 1'b0, "ovr_first");
    send_frame(8'hFE, 1'b0, 1'b0, 1'b0, "ovr_second");
    do_read("ovr_read");
    repeat (10) step();

    // Short low glitch must be rejected
    rx = 1'b0;
    repeat (4) step();
    rx = 1'b1;
    repeat (30) step();
    check_state("glitch");

    // Bad stop bit
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, "frame_err");
    repeat (30) step();
    do_read("ferr_read");
    repeat (10) step();

    // Read/load collision
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, "coll_first");
    repeat (10) step();
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, "collision");
    do_read("coll_read");
    repeat (10) step();

    // Reset during bit 3 of 0x0F
    rx = 1'b0;
    repeat (16) step();
    for (int i = 0; i < 3; i++) begin
      rx = 1'b1;
      repeat (16) step();
    end
    rx = 1'b1;
    repeat (8) step();
    #2 reset = 1'b0;
    m_empty = 1'b1;
    m_rdata = 8'h00;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
    sb_q.delete();
    repeat (3) step();
    reset = 1'b1;
    repeat (40) step();
    check_state("mid_reset");
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, "after_reset");
    do_read("after_reset_read");
`ifdef UART_RX_PARITY_EN
    repeat (10) step();
    send_frame(8'h01, 1'b0, 1'b1, 1'b0, "bad_parity");
    repeat (10) step();
    do_read("bad_parity_read");
`endif
    repeat (10) step();

    // Randomised traffic
    for (int n = 0; n < 24; n++) begin
      d  = 8'($urandom);
      bs = ($urandom_range(0, 5) == 0);
`ifdef UART_RX_PARITY_EN
      bp = ($urandom_range(0, 5) == 0);
`else
      bp = 1'b0;
`endif
      send_frame(d, bs, bp, 1'b0, "rand");
      if ($urandom_range(0, 1) == 1) do_read("rand_read");
      if (bs) repeat (24 + $urandom_range(0, 10)) step();
      else if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 20)) step();
    end
    repeat (10) step();
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
